// File: rtl/cpu_ctrl_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_defs (package)
// Purpose  : Shared state codes for the CPU step controller. The mode
//            display/LED decoder imports the same codes.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_defs;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] state_t;

    localparam state_t S_HALT      = 2'd0;
    localparam state_t S_RUN       = 2'd1;
    localparam state_t S_STEP_IDLE = 2'd2;
    localparam state_t S_STEP_HELD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser plus stable-time debounce for a bouncy
//            push-button. Produces the accepted level and a one-cycle pulse
//            on each accepted rising level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    // Last count value before the level is allowed to flip.
    localparam logic [DB_W-1:0] C_CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;
    logic            w_differ;

    assign w_differ = r_s2 ^ r_level;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive mismatch cycles; accept the new level once it has
    // been stable long enough, otherwise restart the count on any match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_cnt   <= '0;
                r_level <= r_s2;
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : Generates single-cycle CPU advance strobes in the clk domain,
//            either from rising edges of the divided slow clock (RUN) or
//            from debounced step-button presses (STEP).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl
    import cpu_ctrl_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 21,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slow_clk,
    input  logic              btn_step,
    input  logic              run_en,
    input  logic              halt,
    output logic              tick,
    output logic [CNT_W-1:0]  tick_count,
    output logic [MODE_W-1:0] mode,
    output logic              btn_level
);

    logic             r_slow_s1;
    logic             r_slow_s2;
    logic             r_slow_prev;
    logic [1:0]       r_warm;
    logic             w_rise;

    logic             w_press;
    logic             w_level;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_tick_nxt;
    logic             r_tick;
    logic [CNT_W-1:0] r_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_step),
        .o_level (w_level),
        .o_press (w_press)
    );

    // Synchronise slow_clk and keep the previous synced level for edge
    // detection. The sync flops restart from 0 after reset, so "prev" is held
    // at 1 until the synchroniser has delivered a real sample; a slow_clk that
    // is already high at reset release is then taken as the baseline rather
    // than as a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_prev <= 1'b1;
            r_warm      <= 2'b00;
        end else begin
            r_slow_s1   <= slow_clk;
            r_slow_s2   <= r_slow_s1;
            r_slow_prev <= r_warm[1] ? r_slow_s2 : 1'b1;
            r_warm      <= {r_warm[0], 1'b1};
        end
    end

    assign w_rise = r_slow_s2 & ~r_slow_prev;

    // Next-state and tick decision; halt overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = 1'b0;
        if (halt) begin
            w_state_nxt = S_HALT;
        end else begin
            case (r_state)
                S_HALT: begin
                    w_state_nxt = run_en ? S_RUN : S_STEP_IDLE;
                end
                S_RUN: begin
                    w_tick_nxt = w_rise;
                    if (!run_en) begin
                        w_state_nxt = S_STEP_IDLE;
                    end
                end
                S_STEP_IDLE: begin
                    if (run_en) begin
                        w_state_nxt = S_RUN;
                    end else if (w_press) begin
                        w_tick_nxt  = 1'b1;
                        w_state_nxt = S_STEP_HELD;
                    end
                end
                S_STEP_HELD: begin
                    if (run_en) begin
                        w_state_nxt = S_RUN;
                    end else if (!w_level) begin
                        w_state_nxt = S_STEP_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_HALT;
                end
            endcase
        end
    end

    // State register, registered tick and wrapping tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HALT;
            r_tick  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            if (w_tick_nxt) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign tick       = r_tick;
    assign tick_count = r_count;
    assign mode       = r_state;
    assign btn_level  = w_level;

endmodule
`default_nettype wire
